// File: rtl/click_game_pkg.sv
// Shared constants for the two-player counting game: phase encoding and
// the widths of the score and time fields on the display path.
package click_game_pkg;

  localparam int SCORE_W = 7;
  localparam int TIME_W  = 8;

  typedef enum logic [1:0] {
    PH_IDLE      = 2'd0,
    PH_COUNTDOWN = 2'd1,
    PH_PLAY      = 2'd2,
    PH_RESULT    = 2'd3
  } phase_e;

endpackage

// File: rtl/click_game_if.sv
// Player inputs and display-path outputs of the game controller.
// The controller is the slave; the board/bench side is the master.
interface click_game_if;
  import click_game_pkg::*;

  logic              en;
  logic              start;
  logic              D;
  logic              E;
  logic [SCORE_W-1:0] score_d;
  logic [SCORE_W-1:0] score_e;
  logic [TIME_W-1:0]  time_left;
  logic [1:0]         phase;
  logic               tc;
  logic               td;
  logic               tie;

  modport master (
    output en, start, D, E,
    input  score_d, score_e, time_left, phase, tc, td, tie
  );

  modport slave (
    input  en, start, D, E,
    output score_d, score_e, time_left, phase, tc, td, tie
  );

endinterface

// File: rtl/click_edge.sv
// Two-flop synchroniser for a raw button level followed by a registered
// rising-edge pulse, so each press yields exactly one single-cycle pulse.
module click_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic sync3_r;
  logic pulse_r;

  // Synchroniser chain and edge-pulse register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      pulse_r <= sync2_r & ~sync3_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/click_game_ctrl.sv
// Round sequencer: countdown, timed play with per-player click counters,
// then a latched winner. Every display output comes straight from a flop.
module click_game_ctrl
  import click_game_pkg::*;
#(
  parameter int TICK_DIV    = 10,
  parameter int COUNT_TICKS = 3,
  parameter int GAME_TICKS  = 30,
  parameter int MAX_SCORE   = 99
) (
  input  logic         clk,
  input  logic         reset,
  click_game_if.slave  bus
);

  localparam int                  DIV_W      = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0]   COUNT_TIME = TIME_W'(COUNT_TICKS);
  localparam logic [TIME_W-1:0]   GAME_TIME  = TIME_W'(GAME_TICKS);
  localparam logic [TIME_W-1:0]   TIME_ONE   = TIME_W'(1);
  localparam logic [SCORE_W-1:0]  SCORE_MAX  = SCORE_W'(MAX_SCORE);

  phase_e              state_r, state_s;
  logic [DIV_W-1:0]    div_r, div_s;
  logic [TIME_W-1:0]   time_r, time_s;
  logic [SCORE_W-1:0]  sd_r, sd_s, se_r, se_s;
  logic                tc_r, tc_s, td_r, td_s, tie_r, tie_s;
  logic                pulse_d_s, pulse_e_s, tick_s;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v >= SCORE_MAX) ? SCORE_MAX : v + 1'b1;
  endfunction

  click_edge u_edge_d (.clk(clk), .reset(reset), .btn(bus.D), .pulse(pulse_d_s));
  click_edge u_edge_e (.clk(clk), .reset(reset), .btn(bus.E), .pulse(pulse_e_s));

  assign tick_s = bus.en && (div_r == DIV_LAST) &&
                  ((state_r == PH_COUNTDOWN) || (state_r == PH_PLAY));

  // Next-state, divider, timer, score and result-flag logic
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    time_s  = time_r;
    sd_s    = sd_r;
    se_s    = se_r;
    tc_s    = tc_r;
    td_s    = td_r;
    tie_s   = tie_r;
    case (state_r)
      PH_IDLE: begin
        div_s = '0;
        if (bus.start && bus.en) begin
          state_s = PH_COUNTDOWN;
          time_s  = COUNT_TIME;
          sd_s    = '0;
          se_s    = '0;
          tc_s    = 1'b0;
          td_s    = 1'b0;
          tie_s   = 1'b0;
        end else begin
          state_s = PH_IDLE;
        end
      end
      PH_COUNTDOWN: begin
        if (tick_s) begin
          div_s = '0;
          if (time_r == TIME_ONE) begin
            state_s = PH_PLAY;
            time_s  = GAME_TIME;
          end else begin
            time_s = time_r - 1'b1;
          end
        end else if (bus.en) begin
          div_s = div_r + 1'b1;
        end else begin
          div_s = div_r;
        end
      end
      PH_PLAY: begin
        if (bus.en) begin
          sd_s = pulse_d_s ? sat_inc(sd_r) : sd_r;
          se_s = pulse_e_s ? sat_inc(se_r) : se_r;
        end else begin
          sd_s = sd_r;
          se_s = se_r;
        end
        // Flags use the post-click scores so a last-cycle click decides the game
        if (tick_s) begin
          div_s = '0;
          if (time_r == TIME_ONE) begin
            state_s = PH_RESULT;
            time_s  = '0;
            tc_s    = (sd_s > se_s);
            td_s    = (se_s > sd_s);
            tie_s   = (sd_s == se_s);
          end else begin
            time_s = time_r - 1'b1;
          end
        end else if (bus.en) begin
          div_s = div_r + 1'b1;
        end else begin
          div_s = div_r;
        end
      end
      PH_RESULT: begin
        div_s = '0;
        if (!bus.start) begin
          state_s = PH_IDLE;
        end else begin
          state_s = PH_RESULT;
        end
      end
      default: begin
        state_s = PH_IDLE;
        div_s   = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= PH_IDLE;
      div_r   <= '0;
      time_r  <= '0;
      sd_r    <= '0;
      se_r    <= '0;
      tc_r    <= 1'b0;
      td_r    <= 1'b0;
      tie_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      time_r  <= time_s;
      sd_r    <= sd_s;
      se_r    <= se_s;
      tc_r    <= tc_s;
      td_r    <= td_s;
      tie_r   <= tie_s;
    end
  end

  assign bus.score_d   = sd_r;
  assign bus.score_e   = se_r;
  assign bus.time_left = time_r;
  assign bus.phase     = state_r;
  assign bus.tc        = tc_r;
  assign bus.td        = td_r;
  assign bus.tie       = tie_r;

endmodule

// File: tb/tb_click_game_ctrl.sv
// Randomized bench for click_game_ctrl: two instances (normal and low score
// cap) share one stimulus stream and are checked each cycle against a round model.
module tb_click_game_ctrl;
  import click_game_pkg::*;

  localparam int TD    = 4;
  localparam int CT    = 2;
  localparam int GT    = 5;
  localparam int MAX_A = 99;
  localparam int MAX_B = 3;
  localparam int NCYC  = 4000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  click_game_if bus_a ();
  click_game_if bus_b ();

  click_game_ctrl #(.TICK_DIV(TD), .COUNT_TICKS(CT), .GAME_TICKS(GT), .MAX_SCORE(MAX_A))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  click_game_ctrl #(.TICK_DIV(TD), .COUNT_TICKS(CT), .GAME_TICKS(GT), .MAX_SCORE(MAX_B))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  // Reference model: game phase, ticks remaining, clocks into current tick
  int m_phase, m_time, m_sub;
  int m_sd[2], m_se[2], maxs[2];
  bit m_tc[2], m_td[2], m_tie[2];
  bit dh[5], eh[5];

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    if (obs !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_one(input string p, input int i, input logic [1:0] ph,
                             input logic [7:0] tl, input logic [6:0] sd, input logic [6:0] se,
                             input logic tc, input logic td, input logic tie);
    check({p, ".phase"}, 32'(ph), m_phase);
    check({p, ".time_left"}, 32'(tl), m_time);
    check({p, ".score_d"}, 32'(sd), m_sd[i]);
    check({p, ".score_e"}, 32'(se), m_se[i]);
    check({p, ".tc"}, 32'(tc), int'(m_tc[i]));
    check({p, ".td"}, 32'(td), int'(m_td[i]));
    check({p, ".tie"}, 32'(tie), int'(m_tie[i]));
  endtask

  task automatic compare_all();
    compare_one("a", 0, bus_a.phase, bus_a.time_left, bus_a.score_d, bus_a.score_e,
                bus_a.tc, bus_a.td, bus_a.tie);
    compare_one("b", 1, bus_b.phase, bus_b.time_left, bus_b.score_d, bus_b.score_e,
                bus_b.tc, bus_b.td, bus_b.tie);
  endtask

  task automatic model_reset();
    m_phase = 0; m_time = 0; m_sub = 0;
    for (int i = 0; i < 2; i++) begin
      m_sd[i] = 0; m_se[i] = 0; m_tc[i] = 0; m_td[i] = 0; m_tie[i] = 0;
    end
    for (int k = 0; k < 5; k++) begin
      dh[k] = 0; eh[k] = 0;
    end
  endtask

  // A press first seen at edge k is scored at edge k+3
  task automatic model_step(input bit en, input bit st, input bit d, input bit e);
    bit cd, ce;
    for (int k = 4; k > 0; k--) begin
      dh[k] = dh[k-1]; eh[k] = eh[k-1];
    end
    dh[0] = d; eh[0] = e;
    cd = dh[3] & ~dh[4];
    ce = eh[3] & ~eh[4];
    case (m_phase)
      0: if (st && en) begin
        m_phase = 1; m_time = CT; m_sub = 0;
        for (int i = 0; i < 2; i++) begin
          m_sd[i] = 0; m_se[i] = 0; m_tc[i] = 0; m_td[i] = 0; m_tie[i] = 0;
        end
      end
      1: if (en) begin
        if (m_sub == TD - 1) begin
          m_sub = 0; m_time--;
          if (m_time == 0) begin m_phase = 2; m_time = GT; end
        end else m_sub++;
      end
      2: if (en) begin
        for (int i = 0; i < 2; i++) begin
          if (cd && m_sd[i] < maxs[i]) m_sd[i]++;
          if (ce && m_se[i] < maxs[i]) m_se[i]++;
        end
        if (m_sub == TD - 1) begin
          m_sub = 0; m_time--;
          if (m_time == 0) begin
            m_phase = 3;
            for (int i = 0; i < 2; i++) begin
              m_tc[i] = m_sd[i] > m_se[i];
              m_td[i] = m_se[i] > m_sd[i];
              m_tie[i] = m_sd[i] == m_se[i];
            end
          end
        end else m_sub++;
      end
      default: if (!st) m_phase = 0;
    endcase
  endtask

  task automatic drive(input bit en, input bit st, input bit d, input bit e);
    bus_a.en = en; bus_a.start = st; bus_a.D = d; bus_a.E = e;
    bus_b.en = en; bus_b.start = st; bus_b.D = d; bus_b.E = e;
  endtask

  initial begin
    bit en, st, d, e, hold;
    maxs[0] = MAX_A;
    maxs[1] = MAX_B;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    st = 0; d = 0; e = 0; hold = 0;
    repeat (3) @(negedge clk);
    compare_all();
    reset = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      compare_all();
      // Occasional asynchronous reset landing mid-cycle
      if (cyc % 900 == 450) begin
        #2 reset = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        reset = 1'b1;
      end
      if (cyc % 500 == 0) hold = ~hold;
      if ($urandom_range(0, 19) == 0) st = ~st;
      en = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, hold ? 39 : 2) == 0) d = ~d;
      if ($urandom_range(0, 2) == 0) e = ~e;
      drive(en, st, d, e);
      model_step(en, st, d, e);
    end
    @(negedge clk);
    compare_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/click_game_ctrl.md
Name: click_game_ctrl

Overview:
- Round sequencer for the two-player counting game.
- Synchronises and edge-detects the two raw player buttons (D, E) and counts clicks per player.
- Runs a countdown phase and a timed play phase, then latches the winner.
- Feeds the existing seven-segment display path with binary scores, time remaining and phase.

Parameters:
- TICK_DIV, 10: clocks per game tick (the board build overrides it for 1 s ticks); minimum 2.
- COUNT_TICKS, 3: ticks in the pre-game countdown; 1..15.
- GAME_TICKS, 30: ticks in the play phase; 1..255.
- MAX_SCORE, 99: saturation value for each score; ≤127.

Ports:
- clk  in  1: system clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- en  in  1: global enable; low pauses the divider and ignores clicks.
- start  in  1: synchronous level request to begin/arm a round.
- D  in  1: player-D button, asynchronous raw level.
- E  in  1: player-E button, asynchronous raw level.
- score_d  out  7: player-D click count.
- score_e  out  7: player-E click count.
- time_left  out  8: remaining ticks of the current phase.
- phase  out  2: 0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 RESULT.
- tc  out  1: player D won (RESULT only).
- td  out  1: player E won (RESULT only).
- tie  out  1: equal scores (RESULT only).

Behaviour:
- Reset (reset=0, async): phase=IDLE, all counters/scores/time_left=0, tc=td=tie=0, synchroniser flops=0.
- Button path: 2-flop synchroniser, then a rising-edge pulse (sync2 & ~sync3).
  - A level rising before clock edge k increments the score at edge k+3.
  - Holding a button counts once.
- Divider: counts 0..TICK_DIV-1 only in COUNTDOWN/PLAY with en=1; tick = (div==TICK_DIV-1) & en. Cleared to 0 on every state entry.
- IDLE:
  - start=1 & en=1 → COUNTDOWN.
  - On that transition: time_left=COUNT_TICKS, score_d=score_e=0, tc=td=tie=0.
- COUNTDOWN:
  - Each tick decrements time_left.
  - tick with time_left==1 → PLAY, with time_left=GAME_TICKS.
  - Clicks are ignored (no false-start penalty).
- PLAY:
  - Click pulse with en=1 increments the player's score, saturating at MAX_SCORE.
  - Simultaneous D and E pulses both count.
  - Each tick decrements time_left.
  - tick with time_left==1 → RESULT, with time_left=0. A click pulse in that same final cycle is counted.
- RESULT:
  - On entry, registered from the final scores (including a same-cycle last click): tc=(d>e), td=(e>d), tie=(d==e). Exactly one is 1.
  - Scores hold.
  - start=0 → IDLE. Flags and scores hold through IDLE until the next COUNTDOWN entry.
  - start held high keeps RESULT indefinitely; a new round needs start to drop, then rise.
- en=0 in COUNTDOWN/PLAY: divider, time_left and scores freeze; the state is retained; resumes on en=1.
- Reset asserted mid-round: immediate return to reset values; no result flags.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package click_game_pkg:
  - phase encoding constants (PH_IDLE, PH_COUNTDOWN, PH_PLAY, PH_RESULT);
  - score width constant (7);
  - time width constant (8).
- One sub-module, click_edge: 2-flop synchroniser plus rising-edge pulse, same async active-low reset. Instantiated twice (D, E).
- Divider, FSM and score counters live in click_game_ctrl.

Test Plan (TICK_DIV=4, COUNT_TICKS=2, GAME_TICKS=5):
1. Basic round: reset low 30 ns, then en=start=1; D toggles 6 full pulses and E 4 pulses during PLAY (each pulse ≥2 clocks wide) → COUNTDOWN lasts 8 clocks and PLAY 20 clocks; RESULT with score_d=6, score_e=4, tc=1, td=0, tie=0, time_left=0.
2. Countdown ignore and tie: 3 D clicks during COUNTDOWN, then 5 D and 5 E clicks in PLAY → score_d=5, score_e=5, tie=1, tc=td=0.
3. Pause: en=0 for 10 clocks mid-PLAY at time_left=3 → time_left stays 3 and clicks during the pause are not counted; PLAY ends exactly 10 clocks later than in scenario 1.
4. Saturation and hold: MAX_SCORE=3, 5 E clicks, D held high the whole PLAY → score_e=3, score_d=1, td=1.
5. Boundary and restart: E click edge lands on the final PLAY cycle → counted, score_e increments. start held high keeps RESULT; start=0 → IDLE; start=1 → COUNTDOWN with scores cleared.
6. Mid-round reset: reset=0 at time_left=2 in PLAY → phase=0, scores=0, all flags 0 asynchronously, before the next clk edge.
